fifo_mem_sync: RTL and testbench
================================

// Module: fifo_mem_sync
// PURPOSE
// - Single-clock FIFO: dual-port storage plus read/write pointers, occupancy count and status flags.
// - Generalised successor of the FIFO storage array: adds flow control, watermarks, error flags and a read mode.
// - Sits between a producer and a consumer in the same clock domain.
// PARAMETERS
// - DATA_WIDTH  8   word width in bits
// - ADDR_WIDTH  4   pointer width; depth = 1<<ADDR_WIDTH
// - AF_LEVEL    12  almost_full asserted when count >= AF_LEVEL
// - AE_LEVEL    2   almost_empty asserted when count <= AE_LEVEL
// PORTS
// - clk           in   1             clock, all logic on posedge
// - rst_n         in   1             asynchronous reset, active low
// - clr           in   1             synchronous flush
// - w_en          in   1             write request
// - w_data        in   DATA_WIDTH    write data
// - r_en          in   1             read request
// - r_data        out  DATA_WIDTH    read data
// - r_valid       out  1             r_data holds a valid popped/head word
// - full, empty   out  1             occupancy flags
// - almost_full   out  1             count >= AF_LEVEL
// - almost_empty  out  1             count <= AE_LEVEL
// - count         out  ADDR_WIDTH+1  current occupancy, 0..depth
// - overflow      out  1             sticky: w_en seen while full
// - underflow     out  1             sticky: r_en seen while empty
// BEHAVIOUR
// - Reset (rst_n low, async): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0,
//   r_data=0, r_valid=0, overflow=0, underflow=0. Memory contents not reset.
// - Pointers ADDR_WIDTH+1 bits; MSB is wrap bit. empty: ptrs equal; full: addr bits equal, wrap bits differ.
// - Write accepted iff w_en && !full: mem[w_ptr]<=w_data, w_ptr+1 (natural wrap).
// - Read accepted iff r_en && !empty: r_ptr+1.
// - Flags are registered from current state; no same-cycle bypass. Full & w_en & r_en: read only.
//   Empty & w_en & r_en: write only. Neither flag: both accepted, count unchanged.
// - count: +1 write only, -1 read only, else hold. All flags and count valid the cycle after the edge.
// - w_en while full: word dropped, overflow<=1. r_en while empty: no read, underflow<=1.
// - overflow/underflow held until rst_n low or clr.
// - clr: next edge pointers=0, count=0, flags to reset values, r_valid=0, sticky flags cleared;
//   clr has priority over w_en/r_en in the same cycle.
// - Requires 0 < AE_LEVEL < AF_LEVEL < depth; flags derived from count by compare.
// CONFIGURATION
// - Macro FIFO_FWFT_EN.
// - Undefined (standard): r_data registered <= mem[r_ptr] on accepted read; r_valid pulses 1 the cycle
//   after each accepted read; r_data holds last popped word otherwise. Read latency 1.
// - Defined (first-word-fall-through): r_data = mem[r_ptr] combinationally, r_valid = !empty;
//   r_en acts as acknowledge/pop; latency 0. Written word visible the cycle after its write.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=4, AF_LEVEL=12, AE_LEVEL=2)
// - Reset then idle -> empty=1, almost_empty=1, count=0, all other outputs 0.
// - Write 0x00..0x0F (16 words) -> count=16, full=1, almost_full from count=12; 17th write 0xAA
//   -> dropped, overflow=1, count stays 16.
// - Read 16 words -> data 0x00..0x0F in order (r_valid per mode); 17th r_en -> underflow=1, empty=1.
// - Wrap: write 10, read 10, write 10 more -> pointers wrap past 15, reads return correct order, count ok.
// - Simultaneous w_en/r_en at count=5 for 20 cycles -> count stays 5, data order preserved.
// - clr with count=7 and overflow=1, and rst_n pulsed mid-burst -> count=0, empty=1, sticky flags 0.

Source files
------------

// File: rtl/fifo_mem_sync_if.sv
// Producer/consumer bus for fifo_mem_sync: write/read requests, read data and status.
// The master side drives requests; the slave side is the FIFO.
interface fifo_mem_sync_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  clr;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, w_en, w_data, r_en,
    input  r_data, r_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, w_en, w_data, r_en,
    output r_data, r_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_sync.sv
// Single-clock FIFO with registered flags, watermarks and sticky overflow/underflow.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module fifo_mem_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_mem_sync_if.slave  bus
);
  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE_C = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_LVL_C  = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LVL_C  = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   w_ptr_r, r_ptr_r, count_r;
  logic [ADDR_WIDTH:0]   w_ptr_nxt_s, r_ptr_nxt_s, count_nxt_s;
  logic                  full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
  logic                  w_acc_s, r_acc_s;

  // Acceptance uses only the registered flags, so a full FIFO never takes a write
  // even when a read pops in the same cycle.
  always_comb begin
    w_acc_s     = bus.w_en && !full_r;
    r_acc_s     = bus.r_en && !empty_r;
    w_ptr_nxt_s = w_ptr_r;
    r_ptr_nxt_s = r_ptr_r;
    count_nxt_s = count_r;
    if (w_acc_s) begin
      w_ptr_nxt_s = w_ptr_r + PTR_ONE_C;
    end else begin
      w_ptr_nxt_s = w_ptr_r;
    end
    if (r_acc_s) begin
      r_ptr_nxt_s = r_ptr_r + PTR_ONE_C;
    end else begin
      r_ptr_nxt_s = r_ptr_r;
    end
    case ({w_acc_s, r_acc_s})
      2'b10:   count_nxt_s = count_r + PTR_ONE_C;
      2'b01:   count_nxt_s = count_r - PTR_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, status flags and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_r <= '0;
      r_ptr_r <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else if (bus.clr) begin
      w_ptr_r <= '0;
      r_ptr_r <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      w_ptr_r <= w_ptr_nxt_s;
      r_ptr_r <= r_ptr_nxt_s;
      count_r <= count_nxt_s;
      empty_r <= (w_ptr_nxt_s == r_ptr_nxt_s);
      full_r  <= (w_ptr_nxt_s[ADDR_WIDTH-1:0] == r_ptr_nxt_s[ADDR_WIDTH-1:0]) &&
                 (w_ptr_nxt_s[ADDR_WIDTH] != r_ptr_nxt_s[ADDR_WIDTH]);
      af_r    <= (count_nxt_s >= AF_LVL_C);
      ae_r    <= (count_nxt_s <= AE_LVL_C);
      ovf_r   <= ovf_r | (bus.w_en & full_r);
      unf_r   <= unf_r | (bus.r_en & empty_r);
    end
  end

  // Storage array; contents intentionally survive reset and flush.
  always_ff @(posedge clk) begin
    if (w_acc_s && !bus.clr) begin
      mem_r[w_ptr_r[ADDR_WIDTH-1:0]] <= bus.w_data;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.r_data  = mem_r[r_ptr_r[ADDR_WIDTH-1:0]];
  assign bus.r_valid = !empty_r;
`else
  logic [DATA_WIDTH-1:0] r_data_r;
  logic                  r_valid_r;

  // Registered read port: data updates only on an accepted pop, valid pulses once per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_r  <= '0;
      r_valid_r <= 1'b0;
    end else if (bus.clr) begin
      r_valid_r <= 1'b0;
    end else begin
      r_valid_r <= r_acc_s;
      if (r_acc_s) begin
        r_data_r <= mem_r[r_ptr_r[ADDR_WIDTH-1:0]];
      end
    end
  end

  assign bus.r_data  = r_data_r;
  assign bus.r_valid = r_valid_r;
`endif

  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.count        = count_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;
endmodule

// File: tb/tb_fifo_mem_sync.sv
// Directed self-checking bench for fifo_mem_sync in the default (registered-read) build.
module tb_fifo_mem_sync;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fifo_mem_sync_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  fifo_mem_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {full, empty, almost_full, almost_empty, overflow, underflow, r_valid}
  logic [6:0] st;
  assign st = {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
               bus.overflow, bus.underflow, bus.r_valid};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.clr  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.w_data = 8'h00;
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (st !== 7'b0101000) begin
      n_fail++;
      $display("FAIL reset_status got=%b exp=%b", st, 7'b0101000);
    end
    n_checks++;
    if (bus.count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_count got=%0d exp=0", bus.count);
    end
    n_checks++;
    if (bus.r_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata got=%h exp=00", bus.r_data);
    end
  endtask

  task automatic test_fill();
    logic [6:0] exp_st;
    for (int i = 0; i < 16; i++) begin
      bus.w_en   = 1'b1;
      bus.w_data = 8'(i);
      step();
      exp_st = {(i == 15), 1'b0, (i + 1 >= 12), (i + 1 <= 2), 3'b000};
      n_checks++;
      if (bus.count !== 5'(i + 1) || st !== exp_st) begin
        n_fail++;
        $display("FAIL fill_%0d count=%0d st=%b exp count=%0d st=%b", i, bus.count, st, i + 1, exp_st);
      end
    end
    bus.w_data = 8'hAA;
    step();
    bus.w_en = 1'b0;
    n_checks++;
    if (bus.count !== 5'd16 || st !== 7'b1010100) begin
      n_fail++;
      $display("FAIL overflow_write count=%0d st=%b exp count=16 st=1010100", bus.count, st);
    end
  endtask

  task automatic test_drain();
    logic [6:0] exp_st;
    for (int i = 0; i < 16; i++) begin
      bus.r_en = 1'b1;
      step();
      exp_st = {1'b0, (i == 15), (15 - i >= 12), (15 - i <= 2), 1'b1, 1'b0, 1'b1};
      n_checks++;
      if (bus.r_data !== 8'(i) || bus.count !== 5'(15 - i) || st !== exp_st) begin
        n_fail++;
        $display("FAIL drain_%0d data=%h count=%0d st=%b exp data=%h count=%0d st=%b",
                 i, bus.r_data, bus.count, st, 8'(i), 15 - i, exp_st);
      end
    end
    step();
    bus.r_en = 1'b0;
    n_checks++;
    if (st !== 7'b0101110 || bus.r_data !== 8'h0F || bus.count !== 5'd0) begin
      n_fail++;
      $display("FAIL underflow_read st=%b data=%h count=%0d exp st=0101110 data=0f count=0",
               st, bus.r_data, bus.count);
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) begin
        bus.w_en   = 1'b1;
        bus.w_data = 8'(8'h10 + 8'(pass * 32) + 8'(i));
        step();
      end
      bus.w_en = 1'b0;
      n_checks++;
      if (bus.count !== 5'd10) begin
        n_fail++;
        $display("FAIL wrap_count_%0d got=%0d exp=10", pass, bus.count);
      end
      for (int i = 0; i < 10; i++) begin
        bus.r_en = 1'b1;
        step();
        n_checks++;
        if (bus.r_data !== 8'(8'h10 + 8'(pass * 32) + 8'(i)) || bus.r_valid !== 1'b1 ||
            bus.count !== 5'(9 - i)) begin
          n_fail++;
          $display("FAIL wrap_read_%0d_%0d data=%h valid=%b count=%0d", pass, i,
                   bus.r_data, bus.r_valid, bus.count);
        end
      end
      bus.r_en = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    for (int i = 0; i < 5; i++) begin
      bus.w_en   = 1'b1;
      bus.w_data = 8'(8'h50 + 8'(i));
      step();
    end
    for (int k = 0; k < 20; k++) begin
      bus.w_en   = 1'b1;
      bus.r_en   = 1'b1;
      bus.w_data = 8'(8'h60 + 8'(k));
      step();
      exp_d = (k < 5) ? 8'(8'h50 + 8'(k)) : 8'(8'h60 + 8'(k - 5));
      n_checks++;
      if (bus.count !== 5'd5 || bus.r_data !== exp_d || bus.r_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_%0d count=%0d data=%h exp count=5 data=%h", k, bus.count, bus.r_data, exp_d);
      end
    end
    bus.w_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_d = 8'(8'h6F + 8'(i));
      n_checks++;
      if (bus.r_data !== exp_d || bus.count !== 5'(4 - i)) begin
        n_fail++;
        $display("FAIL b2b_tail_%0d data=%h count=%0d exp data=%h", i, bus.r_data, bus.count, exp_d);
      end
    end
    bus.r_en = 1'b0;
  endtask

  task automatic test_clr();
    for (int i = 0; i < 17; i++) begin
      bus.w_en   = 1'b1;
      bus.w_data = 8'(i);
      step();
    end
    bus.w_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.r_en = 1'b1;
      step();
    end
    bus.r_en = 1'b0;
    n_checks++;
    if (bus.count !== 5'd7 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_clr count=%0d ovf=%b exp count=7 ovf=1", bus.count, bus.overflow);
    end
    bus.clr  = 1'b1;
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
    step();
    idle();
    n_checks++;
    if (bus.count !== 5'd0 || st !== 7'b0101000) begin
      n_fail++;
      $display("FAIL clr count=%0d st=%b exp count=0 st=0101000", bus.count, st);
    end
    for (int i = 0; i < 3; i++) begin
      bus.w_en   = 1'b1;
      bus.w_data = 8'(8'hC0 + 8'(i));
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset count=%0d empty=%b exp count=0 empty=1", bus.count, bus.empty);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    bus.w_en = 1'b0;
    step();
    n_checks++;
    if (bus.count !== 5'd0 || st !== 7'b0101000) begin
      n_fail++;
      $display("FAIL post_reset count=%0d st=%b exp count=0 st=0101000", bus.count, st);
    end
    bus.w_en   = 1'b1;
    bus.w_data = 8'h5A;
    step();
    bus.w_en = 1'b0;
    bus.r_en = 1'b1;
    step();
    bus.r_en = 1'b0;
    n_checks++;
    if (bus.r_data !== 8'h5A || bus.r_valid !== 1'b1 || bus.count !== 5'd0) begin
      n_fail++;
      $display("FAIL post_reset_rw data=%h valid=%b count=%0d exp data=5a valid=1 count=0",
               bus.r_data, bus.r_valid, bus.count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
